// File: rtl/instr_fetch_buffer.sv
// Word-granular instruction prefetch queue: fetches aligned 64-bit pairs from local store
// and presents the two oldest 32-bit words to the dual-issue decode stage.
module instr_fetch_buffer #(
    parameter int               WORD         = 32,
    parameter int               DEPTH        = 8,
    parameter int               LS_ADDR_BITS = 18,
    parameter logic [WORD-1:0]  RESET_PC     = {WORD{1'b0}}
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    output logic                      o_imem_req,
    output logic [WORD-1:0]           o_imem_addr,
    input  logic [63:0]               i_imem_rdata,
    input  logic [1:0]                i_consume,
    input  logic                      i_branch_taken,
    input  logic [WORD-1:0]           i_branch_target,
    output logic [WORD-1:0]           o_instr1,
    output logic [WORD-1:0]           o_instr2,
    output logic [WORD-1:0]           o_pc1,
    output logic                      o_valid1,
    output logic                      o_valid2,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LA = LS_ADDR_BITS;
    localparam logic [CW+1:0] DEPTH_C   = (CW+2)'(DEPTH);
    localparam logic [LA-1:0] PAIR_STEP = {{(LA-4){1'b0}}, 4'b1000};
    localparam logic [WORD-1:0] WORD_STEP = {{(WORD-3){1'b0}}, 3'b100};

    logic [WORD-1:0] r_word [DEPTH];
    logic [WORD-1:0] r_pc   [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [LA-1:0]   r_fetch_pc;
    logic [LA-1:0]   r_resp_base;
    logic            r_skip_first;
    logic            r_inflight;
    logic            r_discard;

    logic [CW+1:0]   w_demand;
    logic            w_req;
    logic            w_resp;
    logic [1:0]      w_push_n;
    logic [1:0]      w_cons;
    logic [1:0]      w_pop_n;
    logic [PW-1:0]   w_head_nx1;
    logic [PW-1:0]   w_tail_nx1;
    logic [WORD-1:0] w_base_pc;
    logic [WORD-1:0] w_word0;
    logic [WORD-1:0] w_word1;
    logic            w_unused_bits;

    assign w_unused_bits = ^{i_branch_target[WORD-1:LA], i_branch_target[1:0]};

    // Request decision and per-cycle push/pop amounts.
    always_comb begin
        w_demand   = {2'b00, r_count}
                   + (r_inflight ? {{(CW-1){1'b0}}, 3'b100} : {{(CW-1){1'b0}}, 3'b010});
        w_req      = 1'b0;
        w_push_n   = 2'd0;
        w_cons     = i_consume;
        w_pop_n    = 2'd0;
        w_resp     = r_inflight & ~r_discard;
        w_word0    = WORD'(i_imem_rdata[63:32]);
        w_word1    = WORD'(i_imem_rdata[31:0]);
        w_base_pc  = WORD'(r_resp_base);
        w_head_nx1 = r_head + PW'(1'b1);
        w_tail_nx1 = r_tail + PW'(1'b1);
        // Room is reserved for the pair still in flight; same-cycle consume is not credited.
        if (!i_reset && !i_branch_taken && (w_demand <= DEPTH_C)) begin
            w_req = 1'b1;
        end else begin
            w_req = 1'b0;
        end
        if (!w_resp) begin
            w_push_n = 2'd0;
        end else if (r_skip_first) begin
            w_push_n = 2'd1;
        end else begin
            w_push_n = 2'd2;
        end
        if (i_consume > 2'd2) begin
            w_cons = 2'd2;
        end else begin
            w_cons = i_consume;
        end
        if ({{(CW-2){1'b0}}, w_cons} > r_count) begin
            w_pop_n = r_count[1:0];
        end else begin
            w_pop_n = w_cons;
        end
    end

    // Queue storage writes; entries beyond count are never observed, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (w_push_n == 2'd1) begin
            r_word[r_tail] <= w_word1;
            r_pc[r_tail]   <= w_base_pc + WORD_STEP;
        end else if (w_push_n == 2'd2) begin
            r_word[r_tail]     <= w_word0;
            r_pc[r_tail]       <= w_base_pc;
            r_word[w_tail_nx1] <= w_word1;
            r_pc[w_tail_nx1]   <= w_base_pc + WORD_STEP;
        end
    end

    // Pointer, count and fetch-control state; redirect outranks push and pop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_fetch_pc   <= {RESET_PC[LA-1:3], 3'b000};
            r_resp_base  <= '0;
            r_skip_first <= RESET_PC[2];
            r_inflight   <= 1'b0;
            r_discard    <= 1'b0;
        end else if (i_branch_taken) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_fetch_pc   <= {i_branch_target[LA-1:3], 3'b000};
            r_skip_first <= i_branch_target[2];
            r_inflight   <= w_req;
            r_discard    <= w_req;
        end else begin
            r_inflight <= w_req;
            r_discard  <= 1'b0;
            if (w_req) begin
                r_fetch_pc  <= r_fetch_pc + PAIR_STEP;
                r_resp_base <= r_fetch_pc;
            end
            if (w_resp && r_skip_first) begin
                r_skip_first <= 1'b0;
            end
            r_head  <= r_head + PW'(w_pop_n);
            r_tail  <= r_tail + PW'(w_push_n);
            r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
        end
    end

    // Issue-pair view of the queue head and the memory request port.
    always_comb begin
        o_valid1    = |r_count;
        o_valid2    = (r_count > {{(CW-1){1'b0}}, 1'b1});
        o_count     = r_count;
        o_imem_req  = w_req;
        o_imem_addr = {WORD{1'b0}};
        o_instr1    = {WORD{1'b0}};
        o_pc1       = {WORD{1'b0}};
        o_instr2    = {WORD{1'b0}};
        if (w_req) begin
            o_imem_addr = WORD'(r_fetch_pc);
        end else begin
            o_imem_addr = {WORD{1'b0}};
        end
        if (o_valid1) begin
            o_instr1 = r_word[r_head];
            o_pc1    = r_pc[r_head];
        end else begin
            o_instr1 = {WORD{1'b0}};
            o_pc1    = {WORD{1'b0}};
        end
        if (o_valid2) begin
            o_instr2 = r_word[w_head_nx1];
        end else begin
            o_instr2 = {WORD{1'b0}};
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: hand-computed vector table, a queue-based reference model
// checked every cycle, random traffic and a reset-while-busy sequence.
module tb_instr_fetch_buffer;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] LS_MASK  = 32'h0003_FFFF;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [63:0] imem_rdata;
    logic [1:0]  consume;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr1, instr2, pc1;
    logic        valid1, valid2;
    logic [3:0]  count;

    instr_fetch_buffer #(
        .WORD(32), .DEPTH(DEPTH), .LS_ADDR_BITS(18), .RESET_PC(RESET_PC)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
        .i_consume(consume), .i_branch_taken(branch_taken), .i_branch_target(branch_target),
        .o_instr1(instr1), .o_instr2(instr2), .o_pc1(pc1),
        .o_valid1(valid1), .o_valid2(valid2), .o_count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // memory responder: word at byte address k holds value k
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;

    // reference model: the queue holds pcs (word value == pc with this memory)
    logic [31:0] m_q[$];
    logic [31:0] m_fetch;
    logic [31:0] m_pend_addr;
    bit          m_pend = 1'b0;
    bit          m_skip = 1'b0;
    bit          m_init = 1'b0;

    // samples of the last step
    logic        s_req, s_v1, s_v2;
    logic [31:0] s_addr, s_i1, s_i2, s_pc1;
    logic [3:0]  s_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic br, input logic [31:0] tgt,
                        input logic [1:0] cons);
        bit          e_req;
        logic [31:0] e_addr;
        int          npop;
        @(negedge clk);
        reset         = rst;
        branch_taken  = br;
        branch_target = tgt;
        consume       = cons;
        if (mem_pend) imem_rdata = {mem_addr, mem_addr + 32'd4};
        else          imem_rdata = {$urandom, $urandom};
        #1;
        s_req = imem_req;  s_addr = imem_addr;  s_cnt = count;
        s_v1  = valid1;    s_v2   = valid2;
        s_i1  = instr1;    s_i2   = instr2;     s_pc1 = pc1;
        e_req  = !rst && !br && ((DEPTH - m_q.size() - 2 * int'(m_pend)) >= 2);
        e_addr = e_req ? m_fetch : 32'd0;
        if (m_init) begin
            chk("m_req",   {31'd0, s_req}, {31'd0, e_req});
            chk("m_addr",  s_addr, e_addr);
            chk("m_count", {28'd0, s_cnt}, m_q.size());
            chk("m_valid1", {31'd0, s_v1}, {31'd0, m_q.size() >= 1});
            chk("m_valid2", {31'd0, s_v2}, {31'd0, m_q.size() >= 2});
            chk("m_instr1", s_i1,  (m_q.size() >= 1) ? m_q[0] : 32'd0);
            chk("m_pc1",    s_pc1, (m_q.size() >= 1) ? m_q[0] : 32'd0);
            chk("m_instr2", s_i2,  (m_q.size() >= 2) ? m_q[1] : 32'd0);
        end
        mem_pend = imem_req;
        mem_addr = imem_addr;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_q.delete();
            m_fetch = RESET_PC & 32'h0003_FFF8;
            m_skip  = RESET_PC[2];
            m_pend  = 1'b0;
            m_init  = 1'b1;
        end else if (br) begin
            m_q.delete();
            m_fetch = tgt & 32'h0003_FFF8;
            m_skip  = tgt[2];
            m_pend  = 1'b0;
        end else begin
            npop = (int'(cons) < m_q.size()) ? int'(cons) : m_q.size();
            repeat (npop) void'(m_q.pop_front());
            if (m_pend) begin
                if (m_skip) begin
                    m_q.push_back(m_pend_addr + 32'd4);
                    m_skip = 1'b0;
                end else begin
                    m_q.push_back(m_pend_addr);
                    m_q.push_back(m_pend_addr + 32'd4);
                end
            end
            m_pend = e_req;
            if (e_req) begin
                m_pend_addr = m_fetch;
                m_fetch     = (m_fetch + 32'd8) & LS_MASK;
            end
        end
    endtask

    typedef struct {
        logic        rst, br;
        logic [31:0] tgt;
        logic [1:0]  cons;
        logic        chk;
        logic        e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_cnt;
        logic        e_v1, e_v2;
        logic [31:0] e_i1, e_i2, e_pc1;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic br, input logic [31:0] tgt,
                       input logic [1:0] cons, input logic c, input logic rq,
                       input logic [31:0] ad, input logic [3:0] cn, input logic v1,
                       input logic v2, input logic [31:0] i1, input logic [31:0] i2,
                       input logic [31:0] p1);
        vec_t v;
        v.rst = rst; v.br = br; v.tgt = tgt; v.cons = cons; v.chk = c;
        v.e_req = rq; v.e_addr = ad; v.e_cnt = cn; v.e_v1 = v1; v.e_v2 = v2;
        v.e_i1 = i1; v.e_i2 = i2; v.e_pc1 = p1;
        vq.push_back(v);
    endtask

    logic prev_req;

    initial begin
        reset = 1'b1; branch_taken = 1'b0; branch_target = 32'd0;
        consume = 2'd0; imem_rdata = 64'd0;

        //  rst br tgt           cons chk req addr         cnt v1 v2 i1           i2           pc1
        add(1, 0, 32'h0,       0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,       32'h0);
        add(1, 0, 32'h0,       0, 1, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,       32'h0);
        add(0, 0, 32'h0,       0, 1, 1, 32'h0,       0, 0, 0, 32'h0,       32'h0,       32'h0);
        add(0, 0, 32'h0,       0, 1, 1, 32'h8,       0, 0, 0, 32'h0,       32'h0,       32'h0);
        add(0, 0, 32'h0,       0, 1, 1, 32'h10,      2, 1, 1, 32'h0,       32'h4,       32'h0);
        add(0, 0, 32'h0,       0, 1, 1, 32'h18,      4, 1, 1, 32'h0,       32'h4,       32'h0);
        add(0, 0, 32'h0,       0, 1, 0, 32'h0,       6, 1, 1, 32'h0,       32'h4,       32'h0);
        add(0, 0, 32'h0,       1, 1, 0, 32'h0,       8, 1, 1, 32'h0,       32'h4,       32'h0);
        add(0, 0, 32'h0,       1, 1, 0, 32'h0,       7, 1, 1, 32'h4,       32'h8,       32'h4);
        add(0, 0, 32'h0,       1, 1, 1, 32'h20,      6, 1, 1, 32'h8,       32'hC,       32'h8);
        add(0, 0, 32'h0,       1, 1, 0, 32'h0,       5, 1, 1, 32'hC,       32'h10,      32'hC);
        add(0, 0, 32'h0,       2, 1, 1, 32'h28,      6, 1, 1, 32'h10,      32'h14,      32'h10);
        add(0, 0, 32'h0,       2, 1, 1, 32'h30,      4, 1, 1, 32'h18,      32'h1C,      32'h18);
        add(0, 1, 32'h104,     2, 1, 0, 32'h0,       4, 1, 1, 32'h20,      32'h24,      32'h20);
        add(0, 0, 32'h0,       0, 1, 1, 32'h100,     0, 0, 0, 32'h0,       32'h0,       32'h0);
        add(0, 0, 32'h0,       0, 1, 1, 32'h108,     0, 0, 0, 32'h0,       32'h0,       32'h0);
        add(0, 0, 32'h0,       0, 1, 1, 32'h110,     1, 1, 0, 32'h104,     32'h0,       32'h104);
        add(0, 0, 32'h0,       0, 1, 1, 32'h118,     3, 1, 1, 32'h104,     32'h108,     32'h104);
        add(0, 1, 32'h204,     0, 1, 0, 32'h0,       5, 1, 1, 32'h104,     32'h108,     32'h104);
        add(0, 0, 32'h0,       0, 1, 1, 32'h200,     0, 0, 0, 32'h0,       32'h0,       32'h0);
        add(0, 0, 32'h0,       0, 1, 1, 32'h208,     0, 0, 0, 32'h0,       32'h0,       32'h0);
        add(0, 0, 32'h0,       2, 1, 1, 32'h210,     1, 1, 0, 32'h204,     32'h0,       32'h204);
        add(0, 0, 32'h0,       0, 1, 1, 32'h218,     2, 1, 1, 32'h208,     32'h20C,     32'h208);
        add(0, 1, 32'h3FFF8,   0, 1, 0, 32'h0,       4, 1, 1, 32'h208,     32'h20C,     32'h208);
        add(0, 0, 32'h0,       0, 1, 1, 32'h3FFF8,   0, 0, 0, 32'h0,       32'h0,       32'h0);
        add(0, 0, 32'h0,       0, 1, 1, 32'h0,       0, 0, 0, 32'h0,       32'h0,       32'h0);
        add(0, 0, 32'h0,       1, 1, 1, 32'h8,       2, 1, 1, 32'h3FFF8,   32'h3FFFC,   32'h3FFF8);
        add(0, 0, 32'h0,       1, 1, 1, 32'h10,      3, 1, 1, 32'h3FFFC,   32'h0,       32'h3FFFC);
        add(0, 0, 32'h0,       0, 1, 1, 32'h18,      4, 1, 1, 32'h0,       32'h4,       32'h0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].br, vq[i].tgt, vq[i].cons);
            if (vq[i].chk) begin
                chk("t_req",    {31'd0, s_req}, {31'd0, vq[i].e_req});
                chk("t_addr",   s_addr, vq[i].e_addr);
                chk("t_count",  {28'd0, s_cnt}, {28'd0, vq[i].e_cnt});
                chk("t_valid1", {31'd0, s_v1}, {31'd0, vq[i].e_v1});
                chk("t_valid2", {31'd0, s_v2}, {31'd0, vq[i].e_v2});
                chk("t_instr1", s_i1,  vq[i].e_i1);
                chk("t_instr2", s_i2,  vq[i].e_i2);
                chk("t_pc1",    s_pc1, vq[i].e_pc1);
            end
        end

        // random traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 $urandom & 32'h0003_FFFC, 2'($urandom_range(0, 2)));
        end

        // reset while five words are queued and a pair is in flight
        step(0, 1, 32'h44, 0);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        prev_req = s_req;
        step(1, 0, 32'h0, 0);
        chk("rst5_inflight", {31'd0, prev_req}, 32'd1);
        chk("rst5_count_before", {28'd0, s_cnt}, 32'd5);
        step(0, 0, 32'h0, 0);
        chk("rst5_count", {28'd0, s_cnt}, 32'd0);
        chk("rst5_valid1", {31'd0, s_v1}, 32'd0);
        chk("rst5_instr1", s_i1, 32'd0);
        chk("rst5_pc1", s_pc1, 32'd0);
        chk("rst5_instr2", s_i2, 32'd0);
        chk("rst5_req", {31'd0, s_req}, 32'd1);
        chk("rst5_addr", s_addr, RESET_PC);
        step(0, 0, 32'h0, 0);
        chk("rst5_no_stale_push", {28'd0, s_cnt}, 32'd0);
        step(0, 0, 32'h0, 0);
        chk("rst5_refill_count", {28'd0, s_cnt}, 32'd2);
        chk("rst5_refill_instr1", s_i1, 32'd0);
        chk("rst5_refill_instr2", s_i2, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
